// File: rtl/vga_pad_ctrl_if.sv
// Wishbone-style register bus for vga_pad_ctrl: single-cycle ack per request,
// read data valid only while ack is high; the master holds the request through ack.
interface vga_pad_ctrl_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_ack_o;
  logic [31:0] wb_data_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i,
    input  wb_ack_o, wb_data_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i,
    output wb_ack_o, wb_data_o
  );
endinterface

// File: rtl/vga_pad_ctrl.sv
// VGA-to-pad mux plus debounced buttons with sticky edge IRQ; bus ack 1 cycle, no stall.
// Video latency 0 clk, or 1 clk with VGA_PAD_REG_OUT_EN defined; pads never backpressure.
module vga_pad_ctrl #(
  parameter int COLOR_BITS   = 4,
  parameter int NUM_BUTTONS  = 12,
  parameter int DB_CYCLES    = 65536,
  parameter int VIDEO_BASE   = 12,
  parameter int BTN_BASE     = 26,
  parameter int MPRJ_IO_PADS = 38
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [COLOR_BITS-1:0]   vga_r,
  input  logic [COLOR_BITS-1:0]   vga_g,
  input  logic [COLOR_BITS-1:0]   vga_b,
  input  logic                    vga_hs,
  input  logic                    vga_vs,
  vga_pad_ctrl_if.slave           wb,
  input  logic [MPRJ_IO_PADS-1:0] io_in,
  output logic [MPRJ_IO_PADS-1:0] io_out,
  output logic [MPRJ_IO_PADS-1:0] io_oeb,
  output logic [NUM_BUTTONS-1:0]  buttons_o,
  output logic                    irq_o
);

  localparam int VID_W = 3*COLOR_BITS + 2;
  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  localparam logic [1:0] A_STATE = 2'd0;
  localparam logic [1:0] A_EDGE  = 2'd1;
  localparam logic [1:0] A_MASK  = 2'd2;
  localparam logic [1:0] A_CTRL  = 2'd3;

  logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
  logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
  logic [NUM_BUTTONS-1:0] db_q, db_d;
  logic [NUM_BUTTONS-1:0] db_dly_q, db_dly_d;
  logic [CNT_W-1:0]       cnt_q [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] edge_q, edge_d;
  logic [NUM_BUTTONS-1:0] mask_q, mask_d;
  logic [2:0]             ctrl_q, ctrl_d;
  logic                   irq_q, irq_d;
  logic                   ack_q, ack_d;
  logic [31:0]            rdat_q, rdat_d;

  logic                   req;
  logic                   wr;
  logic [1:0]             sel;
  logic [NUM_BUTTONS-1:0] rise;
  logic [VID_W-1:0]       vid_d;
  logic [VID_W-1:0]       vid_pad;
  logic                   unused_ok;

  assign unused_ok = ^{io_in, wb.wb_data_i, wb.wb_addr_i[1:0]};

  assign req = wb.wb_cyc_i & wb.wb_stb_i;
  // Writes commit on the edge that closes the ack cycle, so a reset during ack drops them.
  assign wr  = ack_q & req & wb.wb_we_i;
  assign sel = wb.wb_addr_i[3:2];

  always_comb begin
    sync1_d  = io_in[BTN_BASE +: NUM_BUTTONS];
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_dly_d = db_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i] = '0;
        db_d[i]  = ~db_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rise   = db_q & ~db_dly_q;
    edge_d = edge_q;
    mask_d = mask_q;
    ctrl_d = ctrl_q;
    if (wr) begin
      case (sel)
        A_EDGE:  edge_d = edge_q & ~wb.wb_data_i[NUM_BUTTONS-1:0];
        A_MASK:  mask_d = wb.wb_data_i[NUM_BUTTONS-1:0];
        A_CTRL:  ctrl_d = wb.wb_data_i[2:0];
        default: ;
      endcase
    end
    // A new press beats a coincident write-1-to-clear.
    edge_d = edge_d | rise;
    irq_d  = |(edge_q & mask_q);
    ack_d  = req & ~ack_q;
    rdat_d = '0;
    if (req && !ack_q) begin
      case (sel)
        A_STATE: rdat_d[NUM_BUTTONS-1:0] = db_q;
        A_EDGE:  rdat_d[NUM_BUTTONS-1:0] = edge_q;
        A_MASK:  rdat_d[NUM_BUTTONS-1:0] = mask_q;
        A_CTRL:  rdat_d[2:0]             = ctrl_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q    <= '{default: '0};
      edge_q   <= '0;
      mask_q   <= '0;
      ctrl_q   <= '0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      ctrl_q   <= ctrl_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
    end
  end

  assign vid_d = {vga_hs ^ ctrl_q[1], vga_vs ^ ctrl_q[2], vga_r, vga_g, vga_b};

`ifdef VGA_PAD_REG_OUT_EN
  logic [VID_W-1:0] vid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_q <= '0;
    end else begin
      vid_q <= vid_d;
    end
  end

  assign vid_pad = vid_q;
`else
  assign vid_pad = vid_d;
`endif

  always_comb begin
    io_out = '0;
    io_oeb = '1;
    io_out[VIDEO_BASE +: VID_W] = vid_pad;
    io_oeb[VIDEO_BASE +: VID_W] = {VID_W{~ctrl_q[0]}};
  end

  assign buttons_o    = db_q;
  assign irq_o        = irq_q;
  assign wb.wb_ack_o  = ack_q;
  assign wb.wb_data_o = rdat_q;

endmodule

// File: tb/tb_vga_pad_ctrl.sv
// Directed bench for vga_pad_ctrl: pad mux, debounce timing, EDGE/IRQ and bus handshake.
// Works with or without VGA_PAD_REG_OUT_EN defined.
module tb_vga_pad_ctrl;
  localparam int CB = 4;
  localparam int NB = 12;
  localparam int DB = 4;
  localparam int VB = 12;
  localparam int BB = 26;
  localparam int NP = 38;

  localparam logic [37:0] OEB_OFF = 38'h3FFFFFFFFF;
  localparam logic [37:0] OEB_ON  = 38'h3FFC000FFF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CB-1:0] vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs;
  logic [NP-1:0] io_in;
  logic [NP-1:0] io_out;
  logic [NP-1:0] io_oeb;
  logic [NB-1:0] buttons;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  vga_pad_ctrl_if bus ();

  vga_pad_ctrl #(
    .COLOR_BITS   (CB),
    .NUM_BUTTONS  (NB),
    .DB_CYCLES    (DB),
    .VIDEO_BASE   (VB),
    .BTN_BASE     (BB),
    .MPRJ_IO_PADS (NP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs),
    .wb        (bus),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .buttons_o (buttons),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vid_settle();
`ifdef VGA_PAD_REG_OUT_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    bus.wb_cyc_i  = 1'b1;
    bus.wb_stb_i  = 1'b1;
    bus.wb_we_i   = 1'b1;
    bus.wb_addr_i = a;
    bus.wb_data_i = d;
    tick();
    check("wr_ack", bus.wb_ack_o, 1);
    tick();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    bus.wb_cyc_i  = 1'b1;
    bus.wb_stb_i  = 1'b1;
    bus.wb_we_i   = 1'b0;
    bus.wb_addr_i = a;
    tick();
    check("rd_ack", bus.wb_ack_o, 1);
    d = bus.wb_data_o;
    tick();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  ackv;
    logic [31:0] dat0, dat1;

    vga_r = '0; vga_g = '0; vga_b = '0; vga_hs = 1'b0; vga_vs = 1'b0;
    io_in = '0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_addr_i = '0; bus.wb_data_i = '0;

    #2;
    check("rst_oeb", io_oeb, OEB_OFF);
    check("rst_out", io_out, 0);
    check("rst_ack", bus.wb_ack_o, 0);
    check("rst_rdat", bus.wb_data_o, 0);
    check("rst_irq", irq, 0);
    check("rst_btn", buttons, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    wb_read(4'hC, d);
    check("ctrl_rst", d, 0);
    wb_write(4'hC, 32'h1);
    check("oeb_en", io_oeb, OEB_ON);

    vga_r = 4'hA; vga_g = 4'h5; vga_b = 4'hF; vga_hs = 1'b1; vga_vs = 1'b0;
`ifdef VGA_PAD_REG_OUT_EN
    #1 check("vid_lat", io_out, 0);
`endif
    vid_settle();
    check("vid_pat1", io_out, 38'h0002A5F000);

    wb_write(4'hC, 32'h7);
    vga_hs = 1'b1; vga_vs = 1'b1;
    vid_settle();
    check("sync_inv", io_out[25:24], 0);
    check("vid_pat2", io_out[25:12], 14'h0A5F);
    vga_hs = 1'b0; vga_vs = 1'b0;
    vid_settle();
    check("vid_pat3", io_out[25:12], 14'h3A5F);
    check("oeb_ctrl7", io_oeb, OEB_ON);

    wb_write(4'hC, 32'hFFFF_FFF9);
    wb_read(4'hC, d);
    check("ctrl_upper0", d, 32'h1);
    wb_write(4'h0, 32'hFFF);
    wb_read(4'h0, d);
    check("state_ro", d, 0);

    // 3-cycle glitch on button 0 must be filtered
    io_in[26] = 1'b1;
    repeat (3) tick();
    io_in[26] = 1'b0;
    repeat (8) tick();
    check("glitch", buttons, 0);
    wb_read(4'h0, d);
    check("glitch_state", d, 0);

    // sync output rises after 2nd edge; debounced bit 4 edges later
    io_in[26] = 1'b1;
    repeat (5) tick();
    check("db_early", buttons[0], 0);
    tick();
    check("db_rise", buttons, 12'h001);
    wb_read(4'h4, d);
    check("edge_same_cyc", d, 0);
    wb_read(4'h4, d);
    check("edge_set", d, 32'h1);
    wb_read(4'h0, d);
    check("state_press", d, 32'h1);
    check("irq_masked", irq, 0);

    wb_write(4'h8, 32'h1);
    check("irq_lag", irq, 0);
    tick();
    check("irq_set", irq, 1);
    wb_read(4'h8, d);
    check("mask_rd", d, 32'h1);

    wb_write(4'h4, 32'h1);
    check("irq_hold", irq, 1);
    tick();
    check("irq_clr", irq, 0);
    wb_read(4'h4, d);
    check("edge_w1c", d, 0);

    io_in[26] = 1'b0;
    repeat (10) tick();
    check("db_fall", buttons, 0);
    wb_read(4'h4, d);
    check("edge_no_fall", d, 0);

    // W1C commit edge coincides with the EDGE set edge
    io_in[26] = 1'b1;
    repeat (5) tick();
    wb_write(4'h4, 32'h1);
    wb_read(4'h4, d);
    check("set_wins", d, 32'h1);

    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_addr_i = 4'h0;
    ackv = '0; dat0 = '0; dat1 = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ackv[i] = bus.wb_ack_o;
      if (i == 0) dat0 = bus.wb_data_o;
      if (i == 1) dat1 = bus.wb_data_o;
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    check("hold_acks", ackv, 4'b0101);
    check("hold_rdat", dat0, 32'h1);
    check("idle_rdat", dat1, 0);
    tick();

    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_addr_i = 4'h8; bus.wb_data_i = 32'hFFF;
    tick();
    check("rst_ack_pre", bus.wb_ack_o, 1);
    reset_n = 1'b0;
    #1;
    check("rst_ack_drop", bus.wb_ack_o, 0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    wb_read(4'h8, d);
    check("mask_after_rst", d, 0);
    check("oeb_after_rst", io_oeb, OEB_OFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
